// File: rtl/rh_dma_seq.sv
// rh_dma_seq: RH11 Unibus DMA word sequencer between the data silo and the Unibus.
// Optional data-late detection is enabled by defining RH_DMA_SEQ_DLT_EN.
module rh_dma_seq #(
   parameter int TIMEOUT = 127
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        devRESET,
   input  logic        rhCLR,
   input  logic        rhGO,
   input  logic        rhDIR,
   input  logic        rhBAI,
   input  logic [15:0] rhWC,
   input  logic [17:0] rhBA,
   input  logic        bufFULL,
   input  logic        bufEMPTY,
   input  logic        drvSTB,
   input  logic        dmaACK,
   output logic        dmaREQ,
   output logic        dmaWR,
   output logic [17:0] dmaADDR,
   output logic        bufPUSH,
   output logic        bufPOP,
   output logic        rhSETNEM,
   output logic        rhSETDLT,
   output logic        rhBUFIR,
   output logic        rhBUFOR,
   output logic        rhBUSY,
   output logic        rhDONE
);
   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_UPD, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [15:0]   wc_q, wc_d;
   logic [17:0]   ba_q, ba_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dir_q, dir_d;
   logic          req_q, req_d, busy_q, busy_d, done_q, done_d;
   logic          nem_q, nem_d, dlt_q, dlt_d;
   logic          bufir_q, bufir_d, bufor_q, bufor_d;
   logic [1:0]    rst_sync_q;
   logic          rst_int, abort, dlt_hit, ack_hit;

   // Sequencer state leaves reset only on a clean edge after rst rises.
   always_ff @(posedge clk or negedge rst)
      if (!rst) rst_sync_q <= 2'b00;
      else      rst_sync_q <= {rst_sync_q[0], 1'b1};

   assign rst_int = rst_sync_q[1];
   assign abort   = devRESET | rhCLR;

`ifdef RH_DMA_SEQ_DLT_EN
   assign dlt_hit = (state_q != S_IDLE) && (state_q != S_DONE) && drvSTB &&
                    (dir_q ? bufEMPTY : bufFULL);
`else
   logic unused_stb;
   assign unused_stb = drvSTB;
   assign dlt_hit    = 1'b0;
`endif

   assign ack_hit = (state_q == S_REQ) && dmaACK && !abort && !dlt_hit;

   always_comb begin
      state_d = state_q;
      wc_d    = wc_q;
      ba_d    = ba_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      nem_d   = 1'b0;
      dlt_d   = 1'b0;
      bufir_d = ~bufFULL;
      bufor_d = ~bufEMPTY;
      if (abort)
         state_d = S_IDLE;
      else if (dlt_hit) begin
         state_d = S_DONE;
         dlt_d   = 1'b1;
      end else
         case (state_q)
            S_IDLE:
               if (rhGO) begin
                  wc_d    = rhWC;
                  ba_d    = rhBA;
                  dir_d   = rhDIR;
                  state_d = S_WAIT;
               end
            S_WAIT:
               if (dir_q ? !bufFULL : !bufEMPTY) begin
                  cnt_d   = '0;
                  state_d = S_REQ;
               end
            S_REQ:
               if (dmaACK)
                  state_d = S_UPD;
               else if (cnt_q == CW'(TIMEOUT)) begin
                  nem_d   = 1'b1;
                  state_d = S_DONE;
               end else
                  cnt_d = cnt_q + 1'b1;
            S_UPD: begin
               wc_d    = wc_q + 16'd1;
               ba_d    = rhBAI ? ba_q : ba_q + 18'd2;
               state_d = (wc_d == 16'd0) ? S_DONE : S_WAIT;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      req_d  = state_d == S_REQ;
      busy_d = state_d != S_IDLE;
      done_d = state_d == S_DONE;
   end

   always_ff @(posedge clk or negedge rst_int)
      if (!rst_int) begin
         state_q <= S_IDLE;
         wc_q    <= '0;
         ba_q    <= '0;
         dir_q   <= 1'b0;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         nem_q   <= 1'b0;
         dlt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wc_q    <= wc_d;
         ba_q    <= ba_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         nem_q   <= nem_d;
         dlt_q   <= dlt_d;
      end

   // Silo status tracks the raw reset so it updates on the first edge after release.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         bufir_q <= 1'b1;
         bufor_q <= 1'b0;
      end else begin
         bufir_q <= bufir_d;
         bufor_q <= bufor_d;
      end

   assign dmaREQ   = req_q;
   assign dmaWR    = req_q & ~dir_q;
   assign dmaADDR  = ba_q;
   assign bufPUSH  = ack_hit & dir_q;
   assign bufPOP   = ack_hit & ~dir_q;
   assign rhSETNEM = nem_q;
   assign rhSETDLT = dlt_q;
   assign rhBUFIR  = bufir_q;
   assign rhBUFOR  = bufor_q;
   assign rhBUSY   = busy_q;
   assign rhDONE   = done_q;
endmodule

// File: tb/tb_rh_dma_seq.sv
// tb_rh_dma_seq: scoreboard bench for rh_dma_seq; a transfer-level model queues the
// expected silo strobes and completion, and a negedge monitor consumes them.
module tb_rh_dma_seq;
   logic        clk = 0, rst = 0, devRESET = 0, rhCLR = 0, rhGO = 0, rhDIR = 0, rhBAI = 0;
   logic [15:0] rhWC = '0;
   logic [17:0] rhBA = '0;
   logic        bufFULL = 0, bufEMPTY = 0, drvSTB = 0, dmaACK = 0;
   logic        dmaREQ, dmaWR, bufPUSH, bufPOP, rhSETNEM, rhSETDLT;
   logic        rhBUFIR, rhBUFOR, rhBUSY, rhDONE;
   logic [17:0] dmaADDR;

   typedef struct {
      bit          done;
      bit          nem;
      bit          dlt;
      bit          dir;
      logic [17:0] addr;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0, n_err = 0, ncyc = 0, req_rise = 0, nem_cyc = -1;
   bit  ack_en = 0, noise = 0, rand_buf = 0, strobe_noise = 0;
   bit  buf_full_set = 0, buf_empty_set = 0, strobe_set = 0, req_prev = 0;

   rh_dma_seq #(.TIMEOUT(127)) dut (
      .clk(clk), .rst(rst), .devRESET(devRESET), .rhCLR(rhCLR), .rhGO(rhGO),
      .rhDIR(rhDIR), .rhBAI(rhBAI), .rhWC(rhWC), .rhBA(rhBA),
      .bufFULL(bufFULL), .bufEMPTY(bufEMPTY), .drvSTB(drvSTB), .dmaACK(dmaACK),
      .dmaREQ(dmaREQ), .dmaWR(dmaWR), .dmaADDR(dmaADDR), .bufPUSH(bufPUSH),
      .bufPOP(bufPOP), .rhSETNEM(rhSETNEM), .rhSETDLT(rhSETDLT), .rhBUFIR(rhBUFIR),
      .rhBUFOR(rhBUFOR), .rhBUSY(rhBUSY), .rhDONE(rhDONE)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Transfer model: one strobe per word at base + 2*i (mod 2^18), then a completion.
   task automatic expect_xfer(logic [15:0] wc, logic [17:0] ba, bit dir, bit bai);
      int  n = (wc == 16'd0) ? 65536 : 65536 - int'(wc);
      ev_t e;
      for (int i = 0; i < n; i++) begin
         e.done = 0; e.nem = 0; e.dlt = 0; e.dir = dir;
         e.addr = bai ? ba : ba + 18'(2 * i);
         exp_q.push_back(e);
      end
      e.done = 1; e.nem = 0; e.dlt = 0; e.dir = dir; e.addr = '0;
      exp_q.push_back(e);
   endtask

   task automatic expect_end(bit nem, bit dlt);
      ev_t e;
      e.done = 1; e.nem = nem; e.dlt = dlt; e.dir = 0; e.addr = '0;
      exp_q.push_back(e);
   endtask

   task automatic go(logic [15:0] wc, logic [17:0] ba, bit dir);
      rhWC = wc; rhBA = ba; rhDIR = dir; rhGO = 1;
      cyc();
      rhGO = 0;
   endtask

   // Waits for the queue to drain and the sequencer to go idle; scrambles GO inputs meanwhile.
   task automatic wait_idle(string name, int budget);
      int k = 0;
      while ((exp_q.size() != 0 || rhBUSY) && k < budget) begin
         rhGO  = rhBUSY && ($urandom_range(0, 7) == 0);
         rhWC  = 16'($urandom);
         rhBA  = 18'($urandom);
         rhDIR = 1'($urandom);
         cyc();
         k++;
      end
      rhGO = 0;
      if (k >= budget) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: not idle after %0d cycles, busy=%b pending=%0d", name, budget, rhBUSY, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic run(string name, logic [15:0] wc, logic [17:0] ba, bit dir, bit bai);
      expect_xfer(wc, ba, dir, bai);
      rhBAI = bai;
      go(wc, ba, dir);
      wait_idle(name, 600);
      chk({name, "_busy_low"}, 32'(rhBUSY), 32'd0);
   endtask

   // Environment: silo status, drive strobe and Unibus acknowledge (after the stimulus slot).
   initial begin
      int dly = 0;
      forever begin
         @(posedge clk);
         #2;
         bufFULL  = rand_buf ? ($urandom_range(0, 3) == 0) : buf_full_set;
         bufEMPTY = rand_buf ? ($urandom_range(0, 3) == 0) : buf_empty_set;
         drvSTB   = strobe_noise ? 1'($urandom) : strobe_set;
         dmaACK   = 0;
         if (dmaREQ && ack_en) begin
            if (dly == 0) begin
               dmaACK = 1;
               dly    = $urandom_range(0, 3);
            end else
               dly--;
         end else if (!dmaREQ && noise)
            dmaACK = ($urandom_range(0, 3) == 0);
      end
   end

   // Monitor: every silo strobe or completion pops the next expected event.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            ncyc++;
            if (dmaREQ && !req_prev) req_rise = ncyc;
            req_prev = dmaREQ;
            if (rhSETNEM) nem_cyc = ncyc;
            if (rhDONE || bufPUSH || bufPOP) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_event: got done=%b push=%b pop=%b expected none at %0t", rhDONE, bufPUSH, bufPOP, $time);
               end else begin
                  ev_t e;
                  e = exp_q.pop_front();
                  chk("event_kind", 32'({rhDONE, bufPUSH, bufPOP}), e.done ? 32'd4 : (e.dir ? 32'd2 : 32'd1));
                  if (e.done)
                     chk("done_flags", 32'({rhSETNEM, rhSETDLT}), 32'({e.nem, e.dlt}));
                  else begin
                     chk("xfer_addr", 32'(dmaADDR), 32'(e.addr));
                     chk("dma_wr", 32'(dmaWR), 32'(!e.dir));
                  end
               end
            end
            if ((rhSETNEM || rhSETDLT) && !rhDONE) begin
               n_cmp++;
               n_err++;
               $display("FAIL stray_error_pulse: got nem=%b dlt=%b without done, expected none at %0t", rhSETNEM, rhSETDLT, $time);
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) cyc();
      @(negedge clk);
      chk("rst_bufir", 32'(rhBUFIR), 32'd1);
      chk("rst_bufor", 32'(rhBUFOR), 32'd0);
      chk("rst_busy", 32'(rhBUSY), 32'd0);
      chk("rst_req", 32'(dmaREQ), 32'd0);
      chk("rst_addr", 32'(dmaADDR), 32'd0);
      chk("rst_pulses", 32'({rhDONE, rhSETNEM, rhSETDLT, bufPUSH, bufPOP}), 32'd0);
      rst = 1;
      #1;
      chk("rel_bufor_hold", 32'(rhBUFOR), 32'd0);
      cyc();
      chk("rel_bufor_upd", 32'(rhBUFOR), 32'd1);
      repeat (3) cyc();

      ack_en = 1;
      run("three_words", 16'o177775, 18'o001000, 1, 0);
      run("three_bai", 16'o177775, 18'o001000, 1, 1);
      run("addr_wrap", 16'o177776, 18'o777776, 0, 0);

      ack_en = 0;
      expect_end(1, 0);
      nem_cyc = -1;
      go(16'o177777, 18'o000100, 0);
      wait_idle("timeout", 400);
      chk("nem_latency", 32'(nem_cyc - req_rise), 32'd128);

      begin
         int k = 0;
         go(16'o177770, 18'o002000, 1);
         while (!dmaREQ && k < 20) begin
            cyc();
            k++;
         end
         chk("clr_req_seen", 32'(dmaREQ), 32'd1);
         repeat (5) cyc();
         rhCLR = 1;
         cyc();
         rhCLR = 0;
         chk("clr_req_low", 32'(dmaREQ), 32'd0);
         chk("clr_busy_low", 32'(rhBUSY), 32'd0);
         chk("clr_addr_hold", 32'(dmaADDR), 32'o002000);
         repeat (5) cyc();
      end

      buf_full_set = 1;
      go(16'o177770, 18'o003000, 1);
      repeat (3) cyc();
      chk("devrst_busy", 32'(rhBUSY), 32'd1);
      devRESET = 1;
      cyc();
      devRESET = 0;
      chk("devrst_idle", 32'(rhBUSY), 32'd0);
      buf_full_set = 0;
      repeat (3) cyc();

`ifdef RH_DMA_SEQ_DLT_EN
      buf_empty_set = 1;
      expect_end(0, 1);
      go(16'o177770, 18'o004000, 1);
      repeat (3) cyc();
      strobe_set = 1;
      cyc();
      strobe_set = 0;
      wait_idle("dlt", 50);
      buf_empty_set = 0;
`else
      strobe_noise = 1;
`endif

      ack_en   = 1;
      noise    = 1;
      rand_buf = 1;
      for (int t = 0; t < 25; t++) begin
         int n = $urandom_range(1, 5);
         run("random", 16'(65536 - n), 18'($urandom), 1'($urandom), 1'($urandom));
      end
      rand_buf = 0;
      noise    = 0;
      repeat (5) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
